// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and fetch constants.
// Reused by the hazard unit and the benches.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2,
      ST_DROP  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP        = 32'h0000_0000;
   localparam logic [31:0] INST_BYTES = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register with asynchronous active-low reset and load enable.
module if_fetch_unit_pc_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] next_pc,
   output logic [31:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= next_pc;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and presents
// {pc+4, instruction} (or a NOP bubble) to the IF/ID register.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hold_i,
   input  logic        glob_stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o
);

   fetch_state_e state, state_nxt;

   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] pc_inc;
   logic        pc_load;

   logic [31:0] inst_buf_p0;
   logic        buf_load;
   logic [31:0] drop_addr;
   logic        drop_load;

   logic        accept;
   logic        redir;
   logic [31:0] redir_target;

   assign redir_target = word_align(redirect_pc_i);
   assign pc_inc       = pc + INST_BYTES;
   assign accept       = (state == ST_READY) & ~hold_i & ~glob_stall_i;
   assign redir        = redirect_i & ~glob_stall_i;

   if_fetch_unit_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .load    (pc_load),
      .next_pc (pc_nxt),
      .pc      (pc)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // A request abandoned by a redirect must still be completed at its original
   // address, so that address is parked here while pc already points at the target.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         inst_buf_p0 <= NOP;
         drop_addr   <= RESET_PC;
      end else begin
         if (buf_load) begin
            inst_buf_p0 <= imem_data_i;
         end
         if (drop_load) begin
            drop_addr <= pc;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_load     = 1'b0;
      pc_nxt      = pc;
      buf_load    = 1'b0;
      drop_load   = 1'b0;
      imem_req_o  = 1'b0;
      imem_addr_o = pc;

      case (state)
         ST_BOOT: begin
            state_nxt = ST_WAIT;
         end

         ST_WAIT: begin
            imem_req_o  = 1'b1;
            imem_addr_o = pc;
            if (imem_ack_i && redir) begin
               pc_load = 1'b1;
               pc_nxt  = redir_target;
            end else if (imem_ack_i) begin
               buf_load  = 1'b1;
               state_nxt = ST_READY;
            end else if (redir) begin
               pc_load   = 1'b1;
               pc_nxt    = redir_target;
               drop_load = 1'b1;
               state_nxt = ST_DROP;
            end
         end

         ST_DROP: begin
            imem_req_o  = 1'b1;
            imem_addr_o = drop_addr;
            if (redir) begin
               pc_load = 1'b1;
               pc_nxt  = redir_target;
            end
            if (imem_ack_i) begin
               state_nxt = ST_WAIT;
            end
         end

         ST_READY: begin
            if (redir) begin
               pc_load   = 1'b1;
               pc_nxt    = redir_target;
               state_nxt = ST_WAIT;
            end else if (accept) begin
               pc_load     = 1'b1;
               pc_nxt      = pc_inc;
               imem_req_o  = 1'b1;
               imem_addr_o = pc_inc;
               if (imem_ack_i) begin
                  buf_load = 1'b1;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end

         default: begin
            state_nxt = ST_BOOT;
         end
      endcase
   end

   // Presentation depends on registered state only.
   assign inst_valid_o = (state == ST_READY);
   assign inst_o       = inst_valid_o ? inst_buf_p0 : NOP;
   assign pc_o         = pc_inc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle table for directed corner cases, then a random
// memory/hold/stall stream checked against a scoreboard queue.
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        hold_i;
   logic        glob_stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        h;
      logic        s;
      logic        r;
      logic [31:0] rpc;
      logic        a;
      logic [31:0] d;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evld;
      logic [31:0] einst;
      logic [31:0] epc;
   } vec_t;

   vec_t        tbl[$];
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   if_fetch_unit #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .hold_i        (hold_i),
      .glob_stall_i  (glob_stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_data_i   (imem_data_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .pc_o          (pc_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic h, input logic s, input logic r, input logic [31:0] rpc,
                               input logic a, input logic [31:0] d, input logic ereq,
                               input logic [31:0] eaddr, input logic evld, input logic [31:0] einst,
                               input logic [31:0] epc);
      vec_t v;
      v = '{h: h, s: s, r: r, rpc: rpc, a: a, d: d, ereq: ereq, eaddr: eaddr,
            evld: evld, einst: einst, epc: epc};
      return v;
   endfunction

   // Called at posedge+1: drive, check before the falling edge, advance one cycle.
   task automatic apply(input vec_t v, input int idx);
      hold_i        = v.h;
      glob_stall_i  = v.s;
      redirect_i    = v.r;
      redirect_pc_i = v.rpc;
      imem_ack_i    = v.a;
      imem_data_i   = v.d;
      #2;
      chk($sformatf("v%0d req", idx), {31'b0, imem_req_o}, {31'b0, v.ereq});
      if (v.ereq) chk($sformatf("v%0d addr", idx), imem_addr_o, v.eaddr);
      chk($sformatf("v%0d valid", idx), {31'b0, inst_valid_o}, {31'b0, v.evld});
      chk($sformatf("v%0d inst", idx), inst_o, v.einst);
      chk($sformatf("v%0d pc", idx), pc_o, v.epc);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        pend;
      logic [31:0] paddr;
      logic [63:0] exp_e;

      rst_i         = 1'b0;
      hold_i        = 1'b0;
      glob_stall_i  = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      imem_ack_i    = 1'b0;
      imem_data_i   = 32'h0;

      //              h  s  r  rpc           a  data          req addr          vld inst          pc_o
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         0, 32'h0,         32'h4));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hA5A5_0000, 1, 32'h0,        0, 32'h0,         32'h4));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hA5A5_0004, 1, 32'h4,        1, 32'hA5A5_0000, 32'h4));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hA5A5_0008, 1, 32'h8,        1, 32'hA5A5_0004, 32'h8));
      tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         1, 32'hA5A5_0008, 32'hC));
      tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         1, 32'hA5A5_0008, 32'hC));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hA5A5_000C, 1, 32'hC,        1, 32'hA5A5_0008, 32'hC));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,        1, 32'hA5A5_000C, 32'h10));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,        1, 32'h10,        0, 32'h0,         32'h14));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h1234_5678, 1, 32'h10,       0, 32'h0,         32'h14));
      tbl.push_back(mk(0, 0, 1, 32'h10,       0, 32'h0,        0, 32'h0,         1, 32'h1234_5678, 32'h14));
      tbl.push_back(mk(0, 0, 1, 32'h40,       0, 32'h0,        1, 32'h10,        0, 32'h0,         32'h14));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,        0, 32'h0,         32'h44));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h10,       0, 32'h0,         32'h44));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,        0, 32'h0,         32'h44));
      tbl.push_back(mk(0, 1, 1, 32'h80,       1, 32'hCAFE_F00D, 1, 32'h40,       0, 32'h0,         32'h44));
      tbl.push_back(mk(0, 1, 1, 32'h80,       0, 32'h0,        0, 32'h0,         1, 32'hCAFE_F00D, 32'h44));
      tbl.push_back(mk(0, 0, 1, 32'h43,       0, 32'h0,        0, 32'h0,         1, 32'hCAFE_F00D, 32'h44));
      tbl.push_back(mk(0, 0, 1, 32'h100,      1, 32'h5555_5555, 1, 32'h40,       0, 32'h0,         32'h44));
      tbl.push_back(mk(0, 0, 1, 32'h200,      0, 32'h0,        1, 32'h100,       0, 32'h0,         32'h104));
      tbl.push_back(mk(0, 0, 1, 32'h300,      0, 32'h0,        1, 32'h100,       0, 32'h0,         32'h204));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_0777, 1, 32'h100,      0, 32'h0,         32'h304));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0BAD_0300, 1, 32'h300,      0, 32'h0,         32'h304));
      tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,       0, 32'h0,         1, 32'h0BAD_0300, 32'h304));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_0013, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0));
      tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         1, 32'h0000_0013, 32'h0));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      #2;
      chk("rst req", {31'b0, imem_req_o}, 32'h0);
      chk("rst valid", {31'b0, inst_valid_o}, 32'h0);
      chk("rst inst", inst_o, NOP);
      chk("rst pc", pc_o, 32'h4);
      @(posedge clk);
      #1;
      rst_i = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // Random stream; the presented instruction (0x13 at 0xFFFFFFFC) is the first entry.
      sb.push_back({32'h0000_0013, 32'h0});
      pend  = 1'b0;
      paddr = 32'h0;
      for (int c = 0; c < 400; c++) begin
         hold_i        = ($urandom_range(0, 3) == 0);
         glob_stall_i  = ($urandom_range(0, 4) == 0);
         redirect_i    = 1'b0;
         imem_ack_i    = 1'b0;
         #1;
         if (pend) begin
            chk("hold req", {31'b0, imem_req_o}, 32'h1);
            chk("hold addr", imem_addr_o, paddr);
         end
         if (imem_req_o && $urandom_range(0, 2) != 0) begin
            imem_ack_i  = 1'b1;
            imem_data_i = imem_addr_o ^ 32'hA5A5_0000;
            sb.push_back({imem_data_i, imem_addr_o + 32'd4});
         end else begin
            imem_data_i = $urandom;
         end
         pend  = imem_req_o & ~imem_ack_i;
         paddr = imem_addr_o;
         #1;
         if (inst_valid_o && !hold_i && !glob_stall_i) begin
            if (sb.size() == 0) begin
               chk("sb empty", 32'h1, 32'h0);
            end else begin
               exp_e = sb.pop_front();
               chk("sb inst", inst_o, exp_e[63:32]);
               chk("sb pc", pc_o, exp_e[31:0]);
            end
         end
         @(posedge clk);
         #1;
      end

      // Asynchronous reset mid-cycle
      hold_i       = 1'b0;
      glob_stall_i = 1'b0;
      imem_ack_i   = 1'b0;
      #2;
      rst_i = 1'b0;
      #1;
      chk("arst req", {31'b0, imem_req_o}, 32'h0);
      chk("arst valid", {31'b0, inst_valid_o}, 32'h0);
      chk("arst inst", inst_o, NOP);
      chk("arst pc", pc_o, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
